// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package sub_pkg;

  localparam int MAX_WIDTH = 32;
  localparam int MIN_CNT_W = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A one-bit operand still needs a one-bit counter so the vector stays legal.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : MIN_CNT_W;
  endfunction

endpackage

// File: rtl/full_sub_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bin, with borrow out.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, with start/busy/done handshake.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q;
  logic             borrow_q;
  logic             d_bit;
  logic             bout_bit;
  logic             accept;
  logic             last;

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign last   = (cnt_q == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Operands are shifted right so the current bit is always at index 0.
  full_sub_cell u_cell (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (br_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  generate
    if (WIDTH == 1) begin : g_diff_one
      assign diff_nxt = d_bit;
    end else begin : g_diff_wide
      assign diff_nxt = {d_bit, diff_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      br_q  <= 1'b0;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      a_q    <= a_q >> 1;
      b_q    <= b_q >> 1;
      br_q   <= bout_bit;
      diff_q <= diff_nxt;
      // Published borrow only moves on the final bit so it holds across IDLE.
      if (last) begin
        borrow_q <= bout_bit;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule
